mem_wb_stage_ctrl: RTL and testbench
====================================

// Module: mem_wb_stage_ctrl
// PURPOSE
//  - Consumes the EX/MEM register outputs and executes the MEM stage of the pipelined CPU.
//  - Issues data-memory requests over a req/ack handshake and stalls upstream stages until access completes.
//  - Selects the writeback value and holds it in the MEM/WB register for the WB stage.
// PARAMETERS
//  DATA_WIDTH      64  width of data, address and writeback paths
//  TIMEOUT_CYCLES  16  ACCESS cycles without ack before abort (only with MEM_TIMEOUT_EN)
// PORTS
//  clk             in   1           single clock, all state on rising edge
//  reset           in   1           asynchronous, active-high
//  MemWrite_EXMEM  in   1           store in MEM stage
//  MemRead_EXMEM   in   1           load in MEM stage
//  RegWrite_EXMEM  in   1           instruction writes register file
//  Mem2Reg_EXMEM   in   2           writeback select: 00 ALU, 01 mem, 10 mult, 11 shift
//  Rd_MEM          in   5           destination register
//  ALUoutMEM       in   DATA_WIDTH  ALU result / memory address
//  MEM_B           in   DATA_WIDTH  store data
//  mult_valMEM     in   DATA_WIDTH  multiplier result
//  shifted_valMEM  in   DATA_WIDTH  shifter result
//  mem_req         out  1           registered request to data memory
//  mem_we          out  1           registered write enable, valid with mem_req
//  mem_addr        out  DATA_WIDTH  = ALUoutMEM (combinational)
//  mem_wdata       out  DATA_WIDTH  = MEM_B (combinational)
//  mem_rdata       in   DATA_WIDTH  load data, valid when mem_ack=1
//  mem_ack         in   1           access complete, sampled only in ACCESS
//  stall_MEM       out  1           hold PC, IF/ID, ID/EX, EX/MEM
//  RegWrite_MEMWB  out  1           registered writeback enable
//  Rd_WB           out  5           registered destination register
//  WB_data         out  DATA_WIDTH  registered writeback value
//  mem_err         out  1           one-cycle timeout pulse (0 without MEM_TIMEOUT_EN)
// BEHAVIOUR
//  - Reset (async): state=IDLE; mem_req, mem_we, RegWrite_MEMWB, Rd_WB, WB_data, mem_err, rdata hold = 0.
//  - Reset mid-ACCESS abandons the request: mem_req drops immediately, no writeback occurs.
//  - mem_op = MemRead_EXMEM | MemWrite_EXMEM; both set counts as a store (mem_we=1).
//  - IDLE: stall_MEM = mem_op. If mem_op: go to ACCESS; set mem_req=1, mem_we=MemWrite_EXMEM.
//  - IDLE, no mem_op: capture into MEM/WB on the edge; one-cycle latency.
//  - ACCESS: stall_MEM=1, mem_req held at 1. On an edge with mem_ack=1:
//    - latch mem_rdata into hold, drop mem_req/mem_we, go to COMPLETE.
//  - COMPLETE: stall_MEM=0; MEM/WB captures on the edge, EX/MEM advances; go to IDLE.
//  - Load with ack in the first ACCESS cycle occupies MEM for 3 cycles (IDLE, ACCESS, COMPLETE).
//  - MEM/WB capture is enabled when stall_MEM=0. While stall_MEM=1, MEM/WB loads a bubble: RegWrite_MEMWB=0.
//  - WB_data mux by Mem2Reg_EXMEM: 00 ALUoutMEM, 01 rdata hold, 10 mult_valMEM, 11 shifted_valMEM.
//  - mem_ack in IDLE/COMPLETE is ignored; mem_addr and mem_wdata stay stable because EX/MEM is held.
// CONFIGURATION
//  - MEM_TIMEOUT_EN defined:
//    - counter counts ACCESS cycles without ack; at TIMEOUT_CYCLES it drops mem_req and pulses mem_err 1 cycle.
//    - rdata hold is set to 0, then the block goes to COMPLETE.
//    - counter clears on entry to ACCESS.
//  - MEM_TIMEOUT_EN undefined: no counter; ACCESS waits indefinitely; mem_err tied 0.
// TESTING
//  - Reset, then ALU op: Mem2Reg=00, ALUoutMEM=3333, Rd=5, RegWrite=1
//    -> stall_MEM=0; next edge WB_data=3333, Rd_WB=5, RegWrite_MEMWB=1.
//  - Load addr 64'h40, ack after 2 ACCESS cycles, rdata=64'hDEAD
//    -> stall_MEM=1 for 3 cycles, mem_req=1 for 2 cycles, WB_data=64'hDEAD; bubble RegWrite_MEMWB=0 while stalled.
//  - Store MEM_B=77 addr 8, ack in 1st cycle
//    -> mem_we=1, mem_wdata=77, mem_addr=8 while mem_req=1; RegWrite_MEMWB=0 after COMPLETE.
//  - Mem2Reg=10/11 with mult_valMEM=12, shifted_valMEM=34 -> WB_data=12 then 34, no stall.
//  - Assert reset during ACCESS -> mem_req=0 and all outputs 0 immediately; stray mem_ack afterwards is ignored.
//  - MEM_TIMEOUT_EN, never ack
//    -> mem_req high for 16 cycles, mem_err pulses once, WB_data=0 after COMPLETE.

Source files
------------

// File: rtl/mem_wb_stage_ctrl_if.sv
// rtl/mem_wb_stage_ctrl_if.sv - data-memory req/ack bus between the MEM stage and data memory
interface mem_wb_stage_ctrl_if #(
  parameter int DATA_WIDTH = 64
);
  logic                  mem_req;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  mem_ack;

  // Pipeline side issues requests
  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  // Memory side answers them
  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/mem_wb_stage_ctrl.sv
// rtl/mem_wb_stage_ctrl.sv - MEM stage control and MEM/WB register; optional access timeout under MEM_TIMEOUT_EN
module mem_wb_stage_ctrl #(
  parameter int DATA_WIDTH     = 64,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  MemWrite_EXMEM,
  input  logic                  MemRead_EXMEM,
  input  logic                  RegWrite_EXMEM,
  input  logic [1:0]            Mem2Reg_EXMEM,
  input  logic [4:0]            Rd_MEM,
  input  logic [DATA_WIDTH-1:0] ALUoutMEM,
  input  logic [DATA_WIDTH-1:0] MEM_B,
  input  logic [DATA_WIDTH-1:0] mult_valMEM,
  input  logic [DATA_WIDTH-1:0] shifted_valMEM,
  mem_wb_stage_ctrl_if.master   bus,
  output logic                  stall_MEM,
  output logic                  RegWrite_MEMWB,
  output logic [4:0]            Rd_WB,
  output logic [DATA_WIDTH-1:0] WB_data,
  output logic                  mem_err
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_ACCESS   = 2'd1,
    S_COMPLETE = 2'd2
  } state_t;

  state_t                r_state;
  logic                  r_mem_req;
  logic                  r_mem_we;
  logic [DATA_WIDTH-1:0] r_rdata_hold;
  logic                  r_regwrite;
  logic [4:0]            r_rd;
  logic [DATA_WIDTH-1:0] r_wb_data;

  logic                  w_mem_op;
  logic                  w_stall;
  logic [DATA_WIDTH-1:0] w_wb_data;

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] r_cnt;
  logic             r_mem_err;
`endif

  // A request with both read and write set is treated as a store
  assign w_mem_op = MemRead_EXMEM | MemWrite_EXMEM;

  // Stall decode: the instruction is held until its access has finished
  always_comb begin
    w_stall = 1'b0;
    case (r_state)
      S_IDLE:   w_stall = w_mem_op;
      S_ACCESS: w_stall = 1'b1;
      default:  w_stall = 1'b0;
    endcase
  end

  // Writeback source select
  always_comb begin
    w_wb_data = ALUoutMEM;
    case (Mem2Reg_EXMEM)
      2'b00:   w_wb_data = ALUoutMEM;
      2'b01:   w_wb_data = r_rdata_hold;
      2'b10:   w_wb_data = mult_valMEM;
      default: w_wb_data = shifted_valMEM;
    endcase
  end

  // Access FSM: issues the request, waits for ack (or timeout), latches load data
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_mem_req    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_rdata_hold <= '0;
`ifdef MEM_TIMEOUT_EN
      r_cnt        <= '0;
      r_mem_err    <= 1'b0;
`endif
    end else begin
`ifdef MEM_TIMEOUT_EN
      r_mem_err <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          if (w_mem_op) begin
            r_state   <= S_ACCESS;
            r_mem_req <= 1'b1;
            r_mem_we  <= MemWrite_EXMEM;
`ifdef MEM_TIMEOUT_EN
            r_cnt     <= '0;
`endif
          end
        end
        S_ACCESS: begin
          if (bus.mem_ack) begin
            r_rdata_hold <= bus.mem_rdata;
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_state      <= S_COMPLETE;
          end
`ifdef MEM_TIMEOUT_EN
          else if (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            r_rdata_hold <= '0;
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_err    <= 1'b1;
            r_state      <= S_COMPLETE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
`endif
        end
        S_COMPLETE: r_state <= S_IDLE;
        default:    r_state <= S_IDLE;
      endcase
    end
  end

  // MEM/WB register: capture when not stalled, otherwise insert a bubble
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_regwrite <= 1'b0;
      r_rd       <= '0;
      r_wb_data  <= '0;
    end else if (!w_stall) begin
      r_regwrite <= RegWrite_EXMEM;
      r_rd       <= Rd_MEM;
      r_wb_data  <= w_wb_data;
    end else begin
      r_regwrite <= 1'b0;
    end
  end

  assign bus.mem_req   = r_mem_req;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = ALUoutMEM;
  assign bus.mem_wdata = MEM_B;

  assign stall_MEM      = w_stall;
  assign RegWrite_MEMWB = r_regwrite;
  assign Rd_WB          = r_rd;
  assign WB_data        = r_wb_data;

`ifdef MEM_TIMEOUT_EN
  assign mem_err = r_mem_err;
`else
  assign mem_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_wb_stage_ctrl.sv
// tb/tb_mem_wb_stage_ctrl.sv - scoreboard bench for mem_wb_stage_ctrl
module tb_mem_wb_stage_ctrl;

  logic        clk;
  logic        reset;
  logic        MemWrite_EXMEM;
  logic        MemRead_EXMEM;
  logic        RegWrite_EXMEM;
  logic [1:0]  Mem2Reg_EXMEM;
  logic [4:0]  Rd_MEM;
  logic [63:0] ALUoutMEM;
  logic [63:0] MEM_B;
  logic [63:0] mult_valMEM;
  logic [63:0] shifted_valMEM;
  logic        stall_MEM;
  logic        RegWrite_MEMWB;
  logic [4:0]  Rd_WB;
  logic [63:0] WB_data;
  logic        mem_err;

  mem_wb_stage_ctrl_if #(.DATA_WIDTH(64)) bus ();

  mem_wb_stage_ctrl #(.DATA_WIDTH(64), .TIMEOUT_CYCLES(16)) dut (
    .clk            (clk),
    .reset          (reset),
    .MemWrite_EXMEM (MemWrite_EXMEM),
    .MemRead_EXMEM  (MemRead_EXMEM),
    .RegWrite_EXMEM (RegWrite_EXMEM),
    .Mem2Reg_EXMEM  (Mem2Reg_EXMEM),
    .Rd_MEM         (Rd_MEM),
    .ALUoutMEM      (ALUoutMEM),
    .MEM_B          (MEM_B),
    .mult_valMEM    (mult_valMEM),
    .shifted_valMEM (shifted_valMEM),
    .bus            (bus),
    .stall_MEM      (stall_MEM),
    .RegWrite_MEMWB (RegWrite_MEMWB),
    .Rd_WB          (Rd_WB),
    .WB_data        (WB_data),
    .mem_err        (mem_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        regw;
    logic [4:0]  rd;
    logic [63:0] data;
  } wb_t;

  wb_t sb[$];

  int n_checks = 0;
  int n_errors = 0;

  // memory responder controls and observations
  int          mem_lat   = 0;
  int          resp_cnt  = 0;
  int          req_cycles = 0;
  int          err_cnt   = 0;
  logic [63:0] rdata_v   = '0;
  logic        exp_we    = 1'b0;
  logic [63:0] exp_addr  = '0;
  logic [63:0] exp_wdata = '0;
  logic        stray_ack = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Memory model: acks on the mem_lat-th request cycle (never when mem_lat==0)
  always @(negedge clk) begin
    if (bus.mem_req === 1'b1) begin
      resp_cnt++;
      req_cycles++;
      chk("mem_we", bus.mem_we, exp_we);
      chk("mem_addr", bus.mem_addr, exp_addr);
      chk("mem_wdata", bus.mem_wdata, exp_wdata);
      if (mem_lat != 0 && resp_cnt == mem_lat) begin
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = rdata_v;
      end else begin
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 64'h0BAD_0BAD_0BAD_0BAD;
      end
    end else begin
      resp_cnt      = 0;
      bus.mem_ack   = stray_ack;
      bus.mem_rdata = 64'hFFFF_EEEE_DDDD_CCCC;
    end
    if (mem_err === 1'b1) err_cnt++;
  end

  task automatic issue(input string tag, input logic rd_en, input logic wr_en, input logic regw,
                       input logic [1:0] m2r, input logic [4:0] rd, input logic [63:0] alu,
                       input logic [63:0] b, input logic [63:0] mult, input logic [63:0] shf,
                       input logic [63:0] rdata, input int lat, input int exp_stall,
                       input int exp_req, input int exp_err);
    wb_t e;
    wb_t got;
    int  stalls;
    @(negedge clk);
    mem_lat        = lat;
    rdata_v        = rdata;
    exp_we         = wr_en;
    exp_addr       = alu;
    exp_wdata      = b;
    req_cycles     = 0;
    err_cnt        = 0;
    MemRead_EXMEM  = rd_en;
    MemWrite_EXMEM = wr_en;
    RegWrite_EXMEM = regw;
    Mem2Reg_EXMEM  = m2r;
    Rd_MEM         = rd;
    ALUoutMEM      = alu;
    MEM_B          = b;
    mult_valMEM    = mult;
    shifted_valMEM = shf;
    e.regw = regw;
    e.rd   = rd;
    case (m2r)
      2'b00:   e.data = alu;
      2'b01:   e.data = (lat == 0) ? 64'h0 : rdata;
      2'b10:   e.data = mult;
      default: e.data = shf;
    endcase
    sb.push_back(e);
    stalls = 0;
    #1;
    for (int i = 0; i < 100 && stall_MEM === 1'b1; i++) begin
      stalls++;
      @(posedge clk);
      #1 chk({tag, "_bubble"}, RegWrite_MEMWB, 1'b0);
      @(negedge clk);
      #1;
    end
    if (stall_MEM !== 1'b0) chk({tag, "_stall_timeout"}, stall_MEM, 1'b0);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    chk({tag, "_regwrite"}, RegWrite_MEMWB, got.regw);
    chk({tag, "_rd"}, Rd_WB, got.rd);
    chk({tag, "_wbdata"}, WB_data, got.data);
    chk({tag, "_stall_cycles"}, stalls, exp_stall);
    chk({tag, "_req_cycles"}, req_cycles, exp_req);
    chk({tag, "_err_pulses"}, err_cnt, exp_err);
  endtask

  initial begin
    reset          = 1'b1;
    MemWrite_EXMEM = 1'b0;
    MemRead_EXMEM  = 1'b0;
    RegWrite_EXMEM = 1'b0;
    Mem2Reg_EXMEM  = 2'b00;
    Rd_MEM         = '0;
    ALUoutMEM      = '0;
    MEM_B          = '0;
    mult_valMEM    = '0;
    shifted_valMEM = '0;
    bus.mem_ack    = 1'b0;
    bus.mem_rdata  = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_mem_req", bus.mem_req, 1'b0);
    chk("rst_mem_we", bus.mem_we, 1'b0);
    chk("rst_regwrite", RegWrite_MEMWB, 1'b0);
    chk("rst_rd", Rd_WB, 5'd0);
    chk("rst_wbdata", WB_data, 64'd0);
    chk("rst_mem_err", mem_err, 1'b0);
    chk("rst_stall", stall_MEM, 1'b0);
    @(negedge clk);
    reset = 1'b0;

    //    tag      rd wr rw m2r    rd     alu           b      mult   shf    rdata          lat stl req err
    issue("alu",   0, 0, 1, 2'b00, 5'd5,  64'd3333,     64'd0, 64'd0, 64'd0, 64'd0,         0,  0,  0,  0);
    issue("load",  1, 0, 1, 2'b01, 5'd7,  64'h40,       64'd0, 64'd0, 64'd0, 64'hDEAD,      2,  3,  2,  0);
    issue("store", 0, 1, 0, 2'b00, 5'd0,  64'd8,        64'd77, 64'd0, 64'd0, 64'h1234,     1,  2,  1,  0);
    issue("mult",  0, 0, 1, 2'b10, 5'd9,  64'd1,        64'd0, 64'd12, 64'd34, 64'd0,       0,  0,  0,  0);
    issue("shift", 0, 0, 1, 2'b11, 5'd10, 64'd1,        64'd0, 64'd12, 64'd34, 64'd0,       0,  0,  0,  0);
    issue("ldst",  1, 1, 1, 2'b01, 5'd31, 64'h1000,     64'h55, 64'd0, 64'd0, 64'hCAFEF00D, 3,  4,  3,  0);
    issue("load1", 1, 0, 1, 2'b01, 5'd3,  64'h48,       64'd0, 64'd0, 64'd0, 64'h0123_4567_89AB_CDEF, 1, 2, 1, 0);
    issue("alu2",  0, 0, 1, 2'b00, 5'd1,  64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'd0, 64'd0, 64'd0, 0, 0, 0, 0);
`ifdef MEM_TIMEOUT_EN
    issue("tmo",   1, 0, 1, 2'b01, 5'd4,  64'h80,       64'd0, 64'd0, 64'd0, 64'hBEEF,      0, 17, 16,  1);
`endif

    // Reset in the middle of an access
    @(negedge clk);
    mem_lat        = 0;
    exp_we         = 1'b0;
    exp_addr       = 64'h200;
    exp_wdata      = 64'd0;
    MemRead_EXMEM  = 1'b1;
    MemWrite_EXMEM = 1'b0;
    RegWrite_EXMEM = 1'b1;
    Mem2Reg_EXMEM  = 2'b01;
    Rd_MEM         = 5'd12;
    ALUoutMEM      = 64'h200;
    MEM_B          = 64'd0;
    repeat (2) @(negedge clk);
    #1 chk("pre_rst_mem_req", bus.mem_req, 1'b1);
    #1 reset = 1'b1;
    #1;
    chk("midrst_mem_req", bus.mem_req, 1'b0);
    chk("midrst_mem_we", bus.mem_we, 1'b0);
    chk("midrst_regwrite", RegWrite_MEMWB, 1'b0);
    chk("midrst_rd", Rd_WB, 5'd0);
    chk("midrst_wbdata", WB_data, 64'd0);
    chk("midrst_mem_err", mem_err, 1'b0);
    @(negedge clk);
    MemRead_EXMEM  = 1'b0;
    RegWrite_EXMEM = 1'b0;
    Mem2Reg_EXMEM  = 2'b00;
    stray_ack      = 1'b1;
    reset          = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk("stray_mem_req", bus.mem_req, 1'b0);
      chk("stray_stall", stall_MEM, 1'b0);
      chk("stray_regwrite", RegWrite_MEMWB, 1'b0);
    end
    stray_ack = 1'b0;

    // A fresh load after the stray acks must still behave normally
    issue("load_post", 1, 0, 1, 2'b01, 5'd6, 64'h60, 64'd0, 64'd0, 64'd0, 64'h7777, 2, 3, 2, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
